iterative_alu: RTL
==================

# iterative_alu

32-bit multi-cycle ALU for the EE471 datapath. Single-cycle operations (add, sub, logic, slt) complete in one clock. Shift-left and multiply iterate one bit per clock. The registered 32-bit result drives the datapath's zero-detect and the register-file write path, with a start/busy/done handshake to the control FSM. N, V and C flags are produced here; the zero flag is derived downstream from `result`.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Accepted only in IDLE.
- `ctrl`  in  3  op select, sampled at accept: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL, 111 MUL.
- `A`  in  32  operand A, sampled at accept.
- `B`  in  32  operand B, sampled at accept. `B[4:0]` is the shift amount for SLL.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse, high while in DONE.
- `result`  out  32  registered result. Held from DONE until the next accept.
- `negative`  out  1  `result[31]`, registered with result.
- `overflow`  out  1  signed overflow, ADD/SUB only; 0 otherwise.
- `carry_out`  out  1  bit-32 carry of A+B (ADD) or A+~B+1 (SUB); 0 otherwise.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → DONE on accept when `ctrl` ∈ {000..101}, or when SLL has shamt=0. `result` and flags are registered on the accepting edge.
- IDLE → RUN on accept for SLL with shamt≠0, or for MUL.
- RUN:
  - SLL: loads `result=A` and `count=shamt` at accept. Each RUN edge does `result<<=1` and `count-=1`. Goes to DONE on the edge where `count` reaches 0.
  - MUL: at accept, loads `acc=0`, `mcand=A`, `mplier=B`, `count=32`. Each RUN edge: `acc+=mcand` if `mplier[0]`, then `mcand<<=1`, `mplier>>=1`, `count-=1`. Goes to DONE when `count` reaches 0. `result` = low 32 bits of the product, written on that edge. This matches both signed and unsigned low products.
- DONE → IDLE unconditionally after one cycle. `start` during RUN or DONE is ignored, not queued.
- Arithmetic rules:
  - SUB computes A+~B+1.
  - V = (A[31]==B'[31]) && (sum[31]!=A[31]), where B'=B for ADD and ~B for SUB.
  - SLT: result = {31'b0, signed(A)<signed(B)}. It must be correct across overflow, e.g. A=0x80000000, B=1 gives 1.
  - SLL and MUL discard overflowed bits; carry_out and overflow are 0 for both.
- `negative` is updated whenever `result` is written. In RUN it tracks intermediate values and is only meaningful in DONE and after.
- Reset in any state:
  - next edge: state=IDLE, result=0, all flags=0, busy=0, done=0, count=0.
  - An in-flight SLL/MUL is aborted with no done pulse.
  - `start` in the reset cycle is ignored.

## Timing
- Accept edge N (IDLE, start=1), latency to `done`:
  - ADD/SUB/logic/SLT, and SLL with shamt=0: done high in the cycle after edge N.
  - SLL with shamt=k≥1: done high after edge N+k.
  - MUL: done high after edge N+32, i.e. 33 cycles from accept to done.
- `busy` is high from the cycle after edge N through the done cycle inclusive.
- Earliest next accept is the edge ending the DONE cycle's successor (IDLE). Back-to-back single-cycle ops therefore accept every 2 cycles.
- `result` is stable from the done cycle until the edge of the next accept.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert reset for 2 cycles, with start=1 and ctrl=111 during reset → busy=0, done=0, result=0, all flags 0 after release.
- ADD overflow: A=0x7FFFFFFF, B=1 → done 1 cycle after accept, result=0x80000000, V=1, C=0, N=1. Then SUB with A=0, B=1 → result=0xFFFFFFFF, C=0, N=1, V=0.
- SLT and logic: SLT A=0x80000000, B=1 → result=1. XOR A=0xFFFF0000, B=0x0F0F0F0F → 0xF0F00F0F. AND with B=0 → result=0, flags 0.
- SLL: A=1, B=31 → done after edge N+31, result=0x80000000. A=5, B=0 → done next cycle, result=5. Pulse start during RUN → ignored, result unchanged.
- MUL: A=0xFFFFFFFF, B=0xFFFFFFFF → done after edge N+32, result=1. A=12345, B=6789 → 83810205. Exactly one done pulse each; busy high for 33 cycles.
- Reset mid-MUL at RUN cycle 10 → no done pulse, result=0, IDLE. A new ADD A=2, B=3 accepted 1 cycle after reset release → result=5.

Source files
------------

// File: rtl/iterative_alu.sv
// Multi-cycle 32-bit ALU: single-cycle add/sub/logic/slt, bit-serial SLL and
// shift-add MUL, with a start/busy/done handshake and registered N/V/C flags.
`timescale 1ns/1ps
module iterative_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        negative,
  output logic        overflow,
  output logic        carry_out
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              is_mul_q, is_mul_d;
  logic [5:0]        count_q, count_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              cout_q, cout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   sum_add, sum_sub;
  logic              slt_bit;

  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              cin);
    return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign sum_add = add_carry(A, B, 1'b0);
  assign sum_sub = add_carry(A, ~B, 1'b1);
  assign slt_bit = ($signed(A) < $signed(B));

  always_comb begin
    state_d  = state_q;
    is_mul_d = is_mul_q;
    count_d  = count_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_DONE;
          is_mul_d = 1'b0;
          ovf_d    = 1'b0;
          cout_d   = 1'b0;
          case (ctrl)
            3'b000: begin
              result_d = sum_add[DATA_W-1:0];
              cout_d   = sum_add[DATA_W];
              ovf_d    = signed_ovf(A[31], B[31], sum_add[31]);
            end
            3'b001: begin
              result_d = sum_sub[DATA_W-1:0];
              cout_d   = sum_sub[DATA_W];
              ovf_d    = signed_ovf(A[31], ~B[31], sum_sub[31]);
            end
            3'b010:  result_d = A & B;
            3'b011:  result_d = A | B;
            3'b100:  result_d = A ^ B;
            3'b101:  result_d = {{(DATA_W-1){1'b0}}, slt_bit};
            3'b110: begin
              result_d = A;
              count_d  = {1'b0, B[4:0]};
              if (B[4:0] != 5'd0) state_d = S_RUN;
            end
            default: begin
              // result_q doubles as the multiply accumulator
              result_d = '0;
              mcand_d  = A;
              mplier_d = B;
              count_d  = 6'd32;
              is_mul_d = 1'b1;
              state_d  = S_RUN;
            end
          endcase
        end
      end
      S_RUN: begin
        if (is_mul_q) begin
          if (mplier_q[0]) result_d = result_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          result_d = result_q << 1;
        end
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    neg_d  = result_d[DATA_W-1];
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_mul_q <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_mul_q <= is_mul_d;
      count_q  <= count_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Multiplier operand shifters carry no control meaning; left unreset
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;

endmodule
